cbm_dispatch_queue: RTL and testbench

Upstream feeder for the column bypass multiplier (CBM). It buffers multiply requests from the execute stage in a small FIFO and launches them one at a time into the CBM start/operand interface. It tracks destination registers with an outstanding multiply in a pending bitmap for hazard stalls. It registers the CBM result onto a single writeback port and supports pipeline flush.

---
 rtl/cbm_pkg.sv | 14 +
 rtl/cbm_req_fifo.sv | 73 +++++++
 rtl/cbm_dispatch_queue.sv | 146 ++++++++++++++
 tb/tb_cbm_dispatch_queue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbm_pkg.sv
// Shared types and constants for the CBM dispatch path.
// The request word is the FIFO payload; latency is CBM start-to-valid in cycles.
package cbm_pkg;

  localparam int CBM_REQ_W   = 69;
  localparam int CBM_LATENCY = 34;

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
  } cbm_req_t;

endpackage

// File: rtl/cbm_req_fifo.sv
// Synchronous FIFO with flush; head is combinational and push-to-head takes one cycle.
// Push is ignored when full and pop when empty; flush empties it and wins over push/pop.
module cbm_req_fifo
  import cbm_pkg::*;
#(
  parameter int WIDTH = CBM_REQ_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_vld_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign push_ok    = push_vld_i && !full_o && !flush_i;
  assign pop_ok     = pop_vld_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count/pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/cbm_dispatch_queue.sv
// Queues multiply requests and launches them into the CBM; start one cycle after accept, writeback 35 after start.
// Requests stall on full, flush or a pending destination (WAW); issue waits for CBM idle.
module cbm_dispatch_queue
  import cbm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [4:0]       req_rd_i,
  input  logic             flush_i,
  output logic             cbm_start_o,
  output logic [31:0]      cbm_op_a_o,
  output logic [31:0]      cbm_op_b_o,
  output logic [4:0]       cbm_rd_idx_o,
  input  logic             cbm_busy_i,
  input  logic             cbm_valid_i,
  input  logic [31:0]      cbm_result_i,
  input  logic [4:0]       cbm_rd_i,
  output logic             wb_valid_o,
  output logic [31:0]      wb_value_o,
  output logic [4:0]       wb_rd_o,
  output logic [31:0]      pending_o,
  output logic [CNT_W-1:0] count_o
);

  cbm_req_t    push_req, head_req;
  logic        fifo_full, fifo_empty, push;
  logic        inflight_q, inflight_d;
  logic [4:0]  inflight_rd_q, inflight_rd_d;
  logic        discard_q, discard_d;
  logic [31:0] pending_q, pending_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_value_q, wb_value_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        keep_inflight;

  always_comb begin
    push_req      = '0;
    push_req.op_a = req_a_i;
    push_req.op_b = req_b_i;
    push_req.rd   = req_rd_i;
  end

  cbm_req_fifo #(
    .WIDTH (CBM_REQ_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_vld_i (push),
    .push_dat_i (push_req),
    .pop_vld_i  (cbm_start_o),
    .flush_i    (flush_i),
    .head_dat_o (head_req),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (count_o)
  );

  assign req_ready_o  = !fifo_full && !flush_i && !((req_rd_i != 5'd0) && pending_q[req_rd_i]);
  assign push         = req_valid_i && req_ready_o;
  // Issuing on the return cycle keeps back-to-back ops exactly CBM_LATENCY apart.
  assign cbm_start_o  = !fifo_empty && !flush_i && !cbm_busy_i && (!inflight_q || cbm_valid_i);
  assign cbm_op_a_o   = head_req.op_a;
  assign cbm_op_b_o   = head_req.op_b;
  assign cbm_rd_idx_o = head_req.rd;

  assign keep_inflight = inflight_q && !cbm_valid_i && (inflight_rd_q != 5'd0) && pending_q[inflight_rd_q];

  always_comb begin
    inflight_d    = inflight_q;
    inflight_rd_d = inflight_rd_q;
    discard_d     = discard_q;
    pending_d     = pending_q;
    wb_valid_d    = 1'b0;
    wb_value_d    = wb_value_q;
    wb_rd_d       = wb_rd_q;

    if (cbm_valid_i) begin
      inflight_d               = 1'b0;
      discard_d                = 1'b0;
      pending_d[inflight_rd_q] = 1'b0;
      if (!discard_q && !flush_i) begin
        wb_valid_d = 1'b1;
        wb_value_d = cbm_result_i;
        wb_rd_d    = cbm_rd_i;
      end
    end

    if (cbm_start_o) begin
      inflight_d    = 1'b1;
      inflight_rd_d = head_req.rd;
    end

    if (push && (req_rd_i != 5'd0)) pending_d[req_rd_i] = 1'b1;

    // The in-flight op cannot be recalled, so its rd stays reserved until the CBM returns.
    if (flush_i) begin
      pending_d                = '0;
      pending_d[inflight_rd_q] = keep_inflight;
      if (inflight_q && !cbm_valid_i) discard_d = 1'b1;
    end

    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      inflight_q    <= 1'b0;
      inflight_rd_q <= '0;
      discard_q     <= 1'b0;
      pending_q     <= '0;
      wb_valid_q    <= 1'b0;
      wb_value_q    <= '0;
      wb_rd_q       <= '0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_rd_q <= inflight_rd_d;
      discard_q     <= discard_d;
      pending_q     <= pending_d;
      wb_valid_q    <= wb_valid_d;
      wb_value_q    <= wb_value_d;
      wb_rd_q       <= wb_rd_d;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_value_o = wb_value_q;
  assign wb_rd_o    = wb_rd_q;
  assign pending_o  = pending_q;

  a_rd_match: assert property (@(posedge clk_i) disable iff (!rst_i)
    cbm_valid_i |-> (cbm_rd_i == inflight_rd_q));
  a_valid_inflight: assert property (@(posedge clk_i) disable iff (!rst_i)
    cbm_valid_i |-> inflight_q);
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_i)
    count_o <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_cbm_dispatch_queue.sv
// Directed bench for cbm_dispatch_queue with a behavioural CBM responder.
// Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
module tb_cbm_dispatch_queue;
  import cbm_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, req_valid_i, flush_i;
  logic        req_ready_o, cbm_start_o, wb_valid_o;
  logic [31:0] req_a_i, req_b_i, cbm_op_a_o, cbm_op_b_o, wb_value_o, pending_o;
  logic [4:0]  req_rd_i, cbm_rd_idx_o, wb_rd_o;
  logic        cbm_busy_i, cbm_valid_i;
  logic [31:0] cbm_result_i;
  logic [4:0]  cbm_rd_i;
  logic [2:0]  count_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int busy_viol = 0;
  int          wb_cyc_q[$];
  logic [31:0] wb_val_q[$];
  logic [4:0]  wb_rd_q[$];
  int          st_cyc_q[$];

  cbm_dispatch_queue dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rd_i(req_rd_i), .flush_i(flush_i),
    .cbm_start_o(cbm_start_o), .cbm_op_a_o(cbm_op_a_o), .cbm_op_b_o(cbm_op_b_o),
    .cbm_rd_idx_o(cbm_rd_idx_o), .cbm_busy_i(cbm_busy_i), .cbm_valid_i(cbm_valid_i),
    .cbm_result_i(cbm_result_i), .cbm_rd_i(cbm_rd_i), .wb_valid_o(wb_valid_o),
    .wb_value_o(wb_value_o), .wb_rd_o(wb_rd_o), .pending_o(pending_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CBM model: busy for LATENCY-1 cycles after start, then a one-cycle valid with a*b.
  initial begin : cbm_model
    logic        s, r;
    logic [31:0] sa, sb, ma, mb;
    logic [4:0]  srd, mrd;
    int          k;
    cbm_busy_i = 1'b0; cbm_valid_i = 1'b0; cbm_result_i = '0; cbm_rd_i = '0;
    ma = '0; mb = '0; mrd = '0; k = 0;
    forever begin
      @(negedge clk_i);
      s = cbm_start_o; sa = cbm_op_a_o; sb = cbm_op_b_o; srd = cbm_rd_idx_o; r = rst_i;
      @(posedge clk_i); #1;
      if (!r) begin
        cbm_busy_i = 1'b0; cbm_valid_i = 1'b0; k = 0;
      end else begin
        cbm_valid_i = 1'b0;
        if (cbm_busy_i) begin
          if (k == CBM_LATENCY - 1) begin
            cbm_busy_i = 1'b0; cbm_valid_i = 1'b1; cbm_result_i = ma * mb; cbm_rd_i = mrd;
          end else k++;
        end
        if (s) begin
          ma = sa; mb = sb; mrd = srd; cbm_busy_i = 1'b1; k = 1;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk_i);
      if (wb_valid_o) begin
        wb_cyc_q.push_back(cyc); wb_val_q.push_back(wb_value_o); wb_rd_q.push_back(wb_rd_o);
      end
      if (cbm_start_o && rst_i) begin
        st_cyc_q.push_back(cyc);
        if (cbm_busy_i) busy_viol++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_logs();
    wb_cyc_q.delete(); wb_val_q.delete(); wb_rd_q.delete(); st_cyc_q.delete();
  endtask

  task automatic wait_wb(input int n, input int budget);
    for (int i = 0; i < budget && wb_cyc_q.size() < n; i++) tick();
    if (wb_cyc_q.size() < n) begin
      n_err++;
      $error("FAIL wait_wb: timeout after %0d cycles, %0d of %0d writebacks seen",
             budget, wb_cyc_q.size(), n);
    end
    chk("wb_count", wb_cyc_q.size(), n);
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req_valid_i = 1'b1; req_a_i = a; req_b_i = b; req_rd_i = rd;
  endtask

  initial begin : stim
    int t0, acc;
    rst_i = 1'b0; req_valid_i = 1'b0; flush_i = 1'b0;
    req_a_i = '0; req_b_i = '0; req_rd_i = '0;
    repeat (2) tick();
    rst_i = 1'b1;
    settle();
    chk("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_wb_value", wb_value_o, 32'h0);
    chk("rst_pending", pending_o, 32'h0);
    chk("rst_count", count_o, 3'd0);
    chk("rst_start", cbm_start_o, 1'b0);
    chk("rst_ready", req_ready_o, 1'b1);

    // Single op: 7*6 into rd 5
    clear_logs();
    tick(); t0 = cyc;
    drive_req(32'd7, 32'd6, 5'd5); settle();
    chk("t1_ready", req_ready_o, 1'b1);
    tick(); req_valid_i = 1'b0; settle();
    chk("t1_start", cbm_start_o, 1'b1);
    chk("t1_op_a", cbm_op_a_o, 32'd7);
    chk("t1_pending", pending_o, 32'h20);
    chk("t1_count", count_o, 3'd1);
    wait_wb(1, 60);
    chk("t1_wb_cyc", wb_cyc_q[0], t0 + 36);
    chk("t1_wb_val", wb_val_q[0], 32'd42);
    chk("t1_wb_rd", wb_rd_q[0], 5'd5);
    chk("t1_pend_clr", pending_o, 32'h0);
    chk("t1_wb_pulse", wb_valid_o, 1'b0);
    chk("t1_wb_hold", wb_value_o, 32'd42);

    // Back-to-back: rd 1..4, a=i, b=all ones
    clear_logs();
    tick(); t0 = cyc;
    for (int i = 1; i <= 4; i++) begin
      drive_req(32'(i), 32'hFFFF_FFFF, 5'(i)); settle();
      chk("t2_ready", req_ready_o, 1'b1);
      tick();
    end
    req_valid_i = 1'b0; settle();
    chk("t2_count3", count_o, 3'd3);
    wait_wb(4, 200);
    chk("t2_starts", st_cyc_q.size(), 4);
    chk("t2_first_start", st_cyc_q[0], t0 + 1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_wb_val", wb_val_q[i], 32'hFFFF_FFFF - 32'(i));
      chk("t2_wb_rd", wb_rd_q[i], 5'(i + 1));
      chk("t2_wb_lat", wb_cyc_q[i] - st_cyc_q[i], 35);
      if (i > 0) chk("t2_start_gap", st_cyc_q[i] - st_cyc_q[i-1], 34);
    end
    chk("t2_busy_start", busy_viol, 0);

    // Full: one in flight plus DEPTH queued, fifth queued request stalls
    clear_logs();
    tick();
    for (int i = 10; i <= 14; i++) begin
      drive_req(32'(i), 32'd2, 5'(i)); tick();
    end
    drive_req(32'd1, 32'd1, 5'd15); settle();
    chk("t3_full_ready", req_ready_o, 1'b0);
    chk("t3_full_count", count_o, 3'd4);
    req_valid_i = 1'b0;
    wait_wb(5, 220);
    for (int i = 0; i < 5; i++) chk("t3_drain_rd", wb_rd_q[i], 5'(i + 10));
    chk("t3_drain_val", wb_val_q[4], 32'd28);

    // WAW: second request to rd 20 waits for the first one's writeback
    clear_logs();
    tick(); t0 = cyc;
    drive_req(32'd100, 32'd3, 5'd20);
    tick(); drive_req(32'd1, 32'd1, 5'd20); settle();
    chk("t3_waw_stall", req_ready_o, 1'b0);
    acc = -1;
    for (int i = 0; i < 60; i++) begin
      if (req_ready_o) begin
        acc = cyc;
        break;
      end
      tick(); settle();
    end
    tick(); req_valid_i = 1'b0;
    chk("t3_waw_accept", acc, t0 + 36);
    wait_wb(2, 80);
    chk("t3_waw_wb0", wb_cyc_q[0], t0 + 36);
    chk("t3_waw_val", wb_val_q[1], 32'd1);
    chk("t3_waw_rd", wb_rd_q[1], 5'd20);

    // Flush with rd 9 in flight and rd 7, 8 queued
    clear_logs();
    tick(); t0 = cyc;
    drive_req(32'd3, 32'd3, 5'd9); tick();
    drive_req(32'd4, 32'd4, 5'd7); tick();
    drive_req(32'd5, 32'd5, 5'd8); tick();
    req_valid_i = 1'b0; settle();
    chk("t4_pend_pre", pending_o, 32'h380);
    chk("t4_count_pre", count_o, 3'd2);
    while (cyc < t0 + 10) tick();
    flush_i = 1'b1; settle();
    chk("t4_flush_ready", req_ready_o, 1'b0);
    chk("t4_flush_start", cbm_start_o, 1'b0);
    tick(); flush_i = 1'b0; settle();
    chk("t4_count", count_o, 3'd0);
    chk("t4_pend_keep", pending_o, 32'h200);
    while (cyc < t0 + 34) tick();
    chk("t4_pend_hold", pending_o, 32'h200);
    while (cyc < t0 + 36) tick();
    chk("t4_pend_clr", pending_o, 32'h0);
    tick();
    chk("t4_no_wb", wb_cyc_q.size(), 0);
    drive_req(32'd5, 32'd9, 5'd9); settle();
    chk("t4_re_ready", req_ready_o, 1'b1);
    tick(); req_valid_i = 1'b0;
    wait_wb(1, 60);
    chk("t4_re_val", wb_val_q[0], 32'd45);
    chk("t4_re_rd", wb_rd_q[0], 5'd9);

    // Flush on the return cycle, then an rd 0 op
    clear_logs();
    tick(); t0 = cyc;
    drive_req(32'd11, 32'd2, 5'd6);
    tick(); req_valid_i = 1'b0;
    while (cyc < t0 + 35) tick();
    flush_i = 1'b1; settle();
    chk("t5_flush_start", cbm_start_o, 1'b0);
    tick(); flush_i = 1'b0; settle();
    chk("t5_pending", pending_o, 32'h0);
    chk("t5_no_wb", wb_valid_o, 1'b0);
    drive_req(32'd2, 32'd3, 5'd0); settle();
    chk("t5_rd0_ready", req_ready_o, 1'b1);
    tick(); req_valid_i = 1'b0; settle();
    chk("t5_rd0_start", cbm_start_o, 1'b1);
    chk("t5_rd0_nopend", pending_o, 32'h0);
    wait_wb(1, 60);
    chk("t5_rd0_val", wb_val_q[0], 32'd6);
    chk("t5_rd0_rd", wb_rd_q[0], 5'd0);

    // Reset during an operation
    clear_logs();
    tick(); t0 = cyc;
    drive_req(32'd4, 32'd4, 5'd3); tick();
    drive_req(32'd2, 32'd2, 5'd4); tick();
    req_valid_i = 1'b0;
    while (cyc < t0 + 10) tick();
    rst_i = 1'b0;
    tick(); rst_i = 1'b1; settle();
    chk("t6_wb_valid", wb_valid_o, 1'b0);
    chk("t6_wb_value", wb_value_o, 32'h0);
    chk("t6_wb_rd", wb_rd_o, 5'd0);
    chk("t6_pending", pending_o, 32'h0);
    chk("t6_count", count_o, 3'd0);
    chk("t6_start", cbm_start_o, 1'b0);
    repeat (50) tick();
    chk("t6_no_wb", wb_cyc_q.size(), 0);
    chk("t6_one_start", st_cyc_q.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
